// File: rtl/pck_wr_ctrl.sv
// Ingress packet write controller: checks each packet's declared length against the received
// word count. Good packets commit their length to the length FIFO; bad ones pulse pck_drop.
module pck_wr_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 12,
  parameter int unsigned MAX_PKT_LEN = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  sw_rst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  len_fifo_full,
  input  logic                  len_fifo_almost_full,
  input  logic                  data_buf_full,
  output logic                  data_wr_en,
  output logic [DATA_WIDTH-1:0] data_wr_data,
  output logic                  len_wr_en,
  output logic [LEN_WIDTH-1:0]  len_wr_data,
  output logic                  pck_drop,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StDrop  = 2'd2;

  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_PKT_LEN);
  localparam logic [LEN_WIDTH-1:0] OneLen = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] OneCnt = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] decl_len_q, decl_len_d;
  logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 hdr_reject;
  logic                 wr, commit, fail, reject;

  assign hdr_len    = in_data[LEN_WIDTH-1:0];
  assign hdr_reject = (hdr_len == '0) || (hdr_len > MaxLen) || len_fifo_full ||
                      len_fifo_almost_full || data_buf_full;

  always_comb begin
    state_d    = state_q;
    decl_len_d = decl_len_q;
    wcnt_d     = wcnt_q;
    wr         = 1'b0;
    commit     = 1'b0;
    fail       = 1'b0;
    reject     = 1'b0;
    if (in_valid) begin
      case (state_q)
        StIdle: begin
          if (in_sop) begin
            if (hdr_reject) begin
              // Nothing reached the buffers, so count it but do not pulse pck_drop.
              reject = 1'b1;
              if (!in_eop) state_d = StDrop;
            end else begin
              decl_len_d = hdr_len;
              wcnt_d     = OneLen;
              if (in_eop) begin
                commit = (hdr_len == OneLen);
                fail   = (hdr_len != OneLen);
              end else begin
                wr      = 1'b1;
                state_d = StWrite;
              end
            end
          end
        end
        StWrite: begin
          if (in_sop) begin
            fail    = 1'b1;
            state_d = StDrop;
          end else if (data_buf_full || (wcnt_q == decl_len_q)) begin
            fail    = 1'b1;
            state_d = in_eop ? StIdle : StDrop;
          end else begin
            wcnt_d = wcnt_q + OneLen;
            if (in_eop) begin
              commit  = (wcnt_d == decl_len_q);
              fail    = (wcnt_d != decl_len_q);
              state_d = StIdle;
            end else begin
              wr = 1'b1;
            end
          end
        end
        StDrop: begin
          if (in_eop) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q      <= StIdle;
      decl_len_q   <= '0;
      wcnt_q       <= '0;
      data_wr_en   <= 1'b0;
      data_wr_data <= '0;
      len_wr_en    <= 1'b0;
      len_wr_data  <= '0;
      pck_drop     <= 1'b0;
      busy         <= 1'b0;
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      state_q    <= state_d;
      decl_len_q <= decl_len_d;
      wcnt_q     <= wcnt_d;
      data_wr_en <= wr | commit;
      len_wr_en  <= commit;
      pck_drop   <= fail;
      busy       <= (state_d != StIdle);
      if (wr || commit) data_wr_data <= in_data;
      if (commit) len_wr_data <= decl_len_d;
      if (commit && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + OneCnt;
      if ((fail || reject) && (drop_cnt != '1)) drop_cnt <= drop_cnt + OneCnt;
    end
  end

endmodule

// File: tb/tb_pck_wr_ctrl.sv
// Bench for pck_wr_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a packet-level reference model.
module tb_pck_wr_ctrl;

  localparam int DW   = 32;
  localparam int LW   = 12;
  localparam int MAXL = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          sw_rst = 1'b1;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          len_fifo_full = 1'b0, len_fifo_almost_full = 1'b0, data_buf_full = 1'b0;
  logic          data_wr_en, len_wr_en, pck_drop, busy;
  logic [DW-1:0] data_wr_data;
  logic [LW-1:0] len_wr_data;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  pck_wr_ctrl #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .MAX_PKT_LEN(MAXL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                 (clk),
    .sw_rst              (sw_rst),
    .in_valid            (in_valid),
    .in_sop              (in_sop),
    .in_eop              (in_eop),
    .in_data             (in_data),
    .len_fifo_full       (len_fifo_full),
    .len_fifo_almost_full(len_fifo_almost_full),
    .data_buf_full       (data_buf_full),
    .data_wr_en          (data_wr_en),
    .data_wr_data        (data_wr_data),
    .len_wr_en           (len_wr_en),
    .len_wr_data         (len_wr_data),
    .pck_drop            (pck_drop),
    .busy                (busy),
    .pkt_cnt             (pkt_cnt),
    .drop_cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the packet in progress as "active" (being written) or "discard"
  // (waiting for eop), with the number of words taken so far.
  bit      m_active = 0, m_discard = 0;
  int      m_n = 0, m_decl = 0, m_pkt = 0, m_drop = 0;
  logic    e_dwe = 0, e_lwe = 0, e_drop = 0, e_busy = 0;
  logic [DW-1:0] e_dwd = '0;
  logic [LW-1:0] e_lwd = '0;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  always @(posedge clk) begin
    int hdr;
    hdr = int'(in_data[LW-1:0]);
    e_dwe = 0; e_lwe = 0; e_drop = 0;
    if (sw_rst) begin
      m_active = 0; m_discard = 0; m_n = 0; m_pkt = 0; m_drop = 0;
      e_dwd = '0; e_lwd = '0;
    end else if (in_valid) begin
      if (m_discard) begin
        if (in_eop) m_discard = 0;
      end else if (!m_active) begin
        if (in_sop) begin
          if (hdr == 0 || hdr > MAXL || len_fifo_full || len_fifo_almost_full || data_buf_full)
          begin
            m_drop = sat(m_drop);
            m_discard = !in_eop;
          end else if (in_eop) begin
            if (hdr == 1) begin
              e_dwe = 1; e_dwd = in_data; e_lwe = 1; e_lwd = LW'(hdr); m_pkt = sat(m_pkt);
            end else begin
              e_drop = 1; m_drop = sat(m_drop);
            end
          end else begin
            e_dwe = 1; e_dwd = in_data; m_active = 1; m_decl = hdr; m_n = 1;
          end
        end
      end else begin
        if (in_sop) begin
          e_drop = 1; m_drop = sat(m_drop); m_active = 0; m_discard = 1;
        end else if (data_buf_full || m_n == m_decl) begin
          e_drop = 1; m_drop = sat(m_drop); m_active = 0; m_discard = !in_eop;
        end else if (in_eop) begin
          m_active = 0;
          if (m_n + 1 == m_decl) begin
            e_dwe = 1; e_dwd = in_data; e_lwe = 1; e_lwd = LW'(m_decl); m_pkt = sat(m_pkt);
          end else begin
            e_drop = 1; m_drop = sat(m_drop);
          end
        end else begin
          e_dwe = 1; e_dwd = in_data; m_n++;
        end
      end
    end
    e_busy = m_active | m_discard;
  end

  // Observed pulse counts for the directed scenarios.
  int obs_dwe = 0, obs_lwe = 0, obs_drop = 0;
  logic [LW-1:0] obs_lwd = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("data_wr_en", 32'(data_wr_en), 32'(e_dwe));
      cmp("data_wr_data", data_wr_data, e_dwd);
      cmp("len_wr_en", 32'(len_wr_en), 32'(e_lwe));
      cmp("len_wr_data", 32'(len_wr_data), 32'(e_lwd));
      cmp("pck_drop", 32'(pck_drop), 32'(e_drop));
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
      cmp("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (data_wr_en === 1'b1) obs_dwe++;
      if (len_wr_en === 1'b1) begin obs_lwe++; obs_lwd = len_wr_data; end
      if (pck_drop === 1'b1) obs_drop++;
    end
  end

  task automatic word(input logic sop, input logic eop, input logic [DW-1:0] d);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_rst();
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
  endtask

  task automatic clr_obs();
    obs_dwe = 0; obs_lwe = 0; obs_drop = 0; obs_lwd = '0;
  endtask

  // Sends a packet of n words whose sop word declares length decl.
  task automatic pkt(input int decl, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (i == 0) d[LW-1:0] = LW'(decl);
      word(i == 0, i == n - 1, d);
    end
  endtask

  initial begin
    idle(2);
    sw_rst = 1'b0;
    chk_en = 1'b1;
    cmp("reset_pkt_cnt", 32'(pkt_cnt), 0);
    cmp("reset_data_wr_en", 32'(data_wr_en), 0);

    // Good 4-word packet
    clr_obs(); pkt(4, 4); idle(2);
    cmp("t1_writes", obs_dwe, 4);
    cmp("t1_len_wr", obs_lwe, 1);
    cmp("t1_len_data", 32'(obs_lwd), 4);
    cmp("t1_pkt_cnt", 32'(pkt_cnt), 1);
    cmp("t1_model_pkt", m_pkt, 1);
    cmp("t1_drops", obs_drop, 0);

    // Single-word packets
    do_rst(); clr_obs(); pkt(1, 1); idle(2);
    cmp("t2_writes", obs_dwe, 1);
    cmp("t2_len_data", 32'(obs_lwd), 1);
    clr_obs(); pkt(2, 1); idle(2);
    cmp("t2b_drops", obs_drop, 1);
    cmp("t2b_drop_cnt", 32'(drop_cnt), 1);
    cmp("t2b_len_wr", obs_lwe, 0);

    // Length mismatches
    do_rst(); clr_obs(); pkt(5, 3); idle(2);
    cmp("t3_writes", obs_dwe, 2);
    cmp("t3_drops", obs_drop, 1);
    pkt(3, 5); idle(2);
    cmp("t3b_writes", obs_dwe, 5);
    cmp("t3b_drops", obs_drop, 2);
    cmp("t3b_drop_cnt", 32'(drop_cnt), 2);
    cmp("t3b_model_drop", m_drop, 2);
    cmp("t3b_busy", 32'(busy), 0);

    // Backpressure at sop
    do_rst(); clr_obs();
    len_fifo_almost_full = 1'b1; word(1'b1, 1'b0, 32'h0000_0008);
    len_fifo_almost_full = 1'b0;
    for (int i = 0; i < 7; i++) word(1'b0, i == 6, $urandom);
    idle(2);
    cmp("t4_writes", obs_dwe, 0);
    cmp("t4_drops", obs_drop, 0);
    cmp("t4_drop_cnt", 32'(drop_cnt), 1);
    pkt(8, 8); idle(2);
    cmp("t4b_pkt_cnt", 32'(pkt_cnt), 1);
    cmp("t4b_len_data", 32'(obs_lwd), 8);

    // Missing eop
    do_rst(); clr_obs();
    word(1'b1, 1'b0, 32'h0000_0004); word(1'b0, 1'b0, $urandom);
    pkt(4, 4); idle(2);
    cmp("t5_writes", obs_dwe, 2);
    cmp("t5_drops", obs_drop, 1);
    cmp("t5_drop_cnt", 32'(drop_cnt), 1);
    cmp("t5_len_wr", obs_lwe, 0);

    // Reset mid-packet
    do_rst(); clr_obs();
    word(1'b1, 1'b0, 32'h0000_0008); word(1'b0, 1'b0, $urandom); word(1'b0, 1'b0, $urandom);
    do_rst(); idle(1);
    cmp("t6_busy", 32'(busy), 0);
    cmp("t6_data_wr_data", data_wr_data, 0);
    cmp("t6_drops", obs_drop, 0);
    pkt(3, 3); idle(2);
    cmp("t6_pkt_cnt", 32'(pkt_cnt), 1);

    // Randomized traffic; small counters so saturation is exercised
    for (int p = 0; p < 400; p++) begin
      int decl, n;
      logic [DW-1:0] d;
      decl = $urandom_range(0, 18);
      n = ($urandom_range(0, 9) < 7) ? ((decl == 0) ? 1 : decl) : $urandom_range(1, 18);
      if ($urandom_range(0, 14) == 0) word(1'b0, $urandom_range(0, 1) == 1, $urandom);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 299) == 0) do_rst();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        len_fifo_full        = ($urandom_range(0, 19) == 0);
        len_fifo_almost_full = ($urandom_range(0, 19) == 0);
        data_buf_full        = ($urandom_range(0, 29) == 0);
        d = $urandom;
        if (i == 0) d[LW-1:0] = LW'(decl);
        // Occasionally leave off the eop so the next sop lands mid-packet.
        word(i == 0, (i == n - 1) && ($urandom_range(0, 19) != 0), d);
      end
      len_fifo_full = 1'b0; len_fifo_almost_full = 1'b0; data_buf_full = 1'b0;
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
